// File: rtl/imem_loader.sv
// Streams a byte sequence into the instruction memory's byte write port and holds the CPU while loading.
// Optional trailing checksum byte verification is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  bytes_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CHK  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W:0] MEM_BYTES = (LEN_W+1)'(1) << ADDR_W;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W:0]    end_addr;
  logic              range_bad;
  logic              start_ok;
  logic              fire;
  logic              write_fire;
  logic              err_set;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
  logic [7:0]        chk_total;
`endif

  // The end-of-load address is one bit wider than len so a full-memory load cannot overflow the check.
  assign end_addr   = {{(LEN_W+1-ADDR_W){1'b0}}, start_addr} + {1'b0, len};
  assign range_bad  = end_addr > MEM_BYTES;
  assign start_ok   = (state == S_IDLE) && start && !range_bad;

`ifdef LOADER_CHECKSUM_EN
  assign in_ready   = ((state == S_LOAD) || (state == S_CHK)) && !abort;
  assign chk_total  = sum + in_data;
`else
  assign in_ready   = (state == S_LOAD) && !abort;
`endif
  assign fire       = in_valid && in_ready;
  assign write_fire = fire && (state == S_LOAD);

  assign busy       = (state != S_IDLE);
  assign cpu_hold   = busy;
  assign done       = (state == S_DONE);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (range_bad)       err_set    = 1'b1;
          else if (len == '0)  next_state = S_DONE;
          else                 next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          next_state = S_IDLE;
          err_set    = 1'b1;
        end else if (fire && (remaining == LEN_W'(1))) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = S_CHK;
`else
          next_state = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (abort) begin
          next_state = S_IDLE;
          err_set    = 1'b1;
        end else if (fire) begin
          if (chk_total == 8'd0) begin
            next_state = S_DONE;
          end else begin
            next_state = S_IDLE;
            err_set    = 1'b1;
          end
        end
      end
`endif
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      bytes_done <= '0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= next_state;
      mem_we <= write_fire;
      if (write_fire) begin
        mem_addr   <= addr;
        mem_wdata  <= in_data;
        addr       <= addr + ADDR_W'(1);
        remaining  <= remaining - LEN_W'(1);
        bytes_done <= bytes_done + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
        sum        <= sum + in_data;
`endif
      end
      if (start_ok) begin
        addr       <= start_addr;
        remaining  <= len;
        bytes_done <= '0;
        err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and checked when mem_we fires.
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
module tb_imem_loader;
  localparam int ADDR_W = 14;
  localparam int LEN_W  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  bytes_done;

  imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .bytes_done(bytes_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  logic prev_valid = 1'b0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0] mem_model [0:(1<<ADDR_W)-1];

  always @(posedge clk) prev_valid <= in_valid;

  // Scoreboard monitor: every write must match the oldest queued byte and follow a cycle where a byte was offered.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [ADDR_W+7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e || !prev_valid) begin
          errors++;
          $display("FAIL write_order: got addr=%0d data=%h prev_valid=%b, required addr=%0d data=%h prev_valid=1",
                   mem_addr, mem_wdata, prev_valid, e[ADDR_W+7:8], e[7:0]);
        end
      end
      mem_model[mem_addr] = mem_wdata;
      wr_count++;
    end
    if (done === 1'b1) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    start = 1'b1; start_addr = a; len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic send_stream(input logic [ADDR_W-1:0] base, input logic [63:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = bytes[63-8*i -: 8];
      exp_q.push_back({ADDR_W'(base + ADDR_W'(i)), b});
      send_byte(b, gap);
    end
  endtask

  task automatic finish_chk(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    send_byte(c, 0);
`else
    if (c == 8'hxx) tick();
`endif
  endtask

  task automatic drain();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    checks++;
    if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000", {in_ready, mem_we, cpu_hold, busy, done, err});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || bytes_done !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d data=%h bytes=%0d, required 0", mem_addr, mem_wdata, bytes_done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic(input int gap, input string name);
    int d0 = done_count;
    int w0 = wr_count;
    do_start(14'd100, 15'd4);
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: got busy=%b hold=%b err=%b, required 1 1 0", name, busy, cpu_hold, err);
    end
    send_stream(14'd100, 64'h4808_0000_0000_0000, 4, gap);
    finish_chk(8'hB0);
    checks++;
    if (done !== 1'b1 || bytes_done !== 15'd4) begin
      errors++;
      $display("FAIL %s_done: got done=%b bytes=%0d, required 1 4", name, done, bytes_done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got done=%b busy=%b hold=%b, required 0 0 0", name, done, busy, cpu_hold);
    end
    drain();
    checks++;
    if ({mem_model[100], mem_model[101], mem_model[102], mem_model[103]} !== 32'h48080000 ||
        wr_count - w0 != 4 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL %s_word: got word=%h writes=%0d dones=%0d, required 48080000 4 1", name,
               {mem_model[100], mem_model[101], mem_model[102], mem_model[103]}, wr_count - w0, done_count - d0);
    end
  endtask

  task automatic test_range();
    int w0 = wr_count;
    do_start(14'd16382, 15'd4);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL range_err: got err=%b busy=%b hold=%b, required 1 0 0", err, busy, cpu_hold);
    end
    repeat (4) tick();
    checks++;
    if (wr_count != w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_nowrite: got writes=%0d busy=%b, required 0 0", wr_count - w0, busy);
    end
    // Exactly fills the top of memory: must be accepted and clear the sticky error.
    do_start(14'd16380, 15'd4);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL range_edge: got err=%b busy=%b, required 0 1", err, busy);
    end
    send_stream(14'd16380, 64'h0102_0304_0000_0000, 4, 1);
    finish_chk(8'hF6);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL range_edge_done: got %b, required 1", done);
    end
    drain();
  endtask

  task automatic test_abort();
    int d0 = done_count;
    int w0 = wr_count;
    do_start(14'd300, 15'd8);
    send_stream(14'd300, 64'h1122_0000_0000_0000, 2, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL abort_cycle: got in_ready=%b mem_we=%b, required 0 1", in_ready, mem_we);
    end
    tick();
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || bytes_done !== 15'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b err=%b bytes=%0d ready=%b, required 0 1 2 0",
               busy, err, bytes_done, in_ready);
    end
    drain();
    checks++;
    if (wr_count - w0 != 2 || done_count != d0) begin
      errors++;
      $display("FAIL abort_counts: got writes=%0d dones=%0d, required 2 0", wr_count - w0, done_count - d0);
    end
  endtask

  task automatic test_len0();
    int w0 = wr_count;
    do_start(14'd50, 15'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: got done=%b busy=%b hold=%b err=%b, required 1 1 1 0", done, busy, cpu_hold, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_count != w0) begin
      errors++;
      $display("FAIL len0_after: got done=%b busy=%b writes=%0d, required 0 0 0", done, busy, wr_count - w0);
    end
  endtask

  task automatic test_back_to_back();
    do_start(14'd400, 15'd2);
    do_start(14'd16382, 15'd4);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: got err=%b busy=%b, required 0 1", err, busy);
    end
    send_stream(14'd400, 64'hAA55_0000_0000_0000, 2, 0);
    finish_chk(8'h01);
    checks++;
    if (done !== 1'b1 || bytes_done !== 15'd2) begin
      errors++;
      $display("FAIL busy_done: got done=%b bytes=%0d, required 1 2", done, bytes_done);
    end
    drain();
  endtask

  task automatic test_reset_midload();
    do_start(14'd600, 15'd8);
    send_stream(14'd600, 64'h7E00_0000_0000_0000, 1, 0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0 || bytes_done !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_midload: got we=%b busy=%b hold=%b bytes=%0d ready=%b, required all 0",
               mem_we, busy, cpu_hold, bytes_done, in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    drain();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int d0 = done_count;
    do_start(14'd500, 15'd4);
    send_stream(14'd500, 64'h2413_0005_0000_0000, 4, 0);
    send_byte(8'hC4, 0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL chk_good: got done=%b err=%b, required 1 0", done, err);
    end
    drain();
    do_start(14'd500, 15'd4);
    send_stream(14'd500, 64'h2413_0005_0000_0000, 4, 0);
    send_byte(8'hC5, 0);
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL chk_bad: got done=%b err=%b busy=%b, required 0 1 0", done, err, busy);
    end
    drain();
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL chk_dones: got %0d, required 1", done_count - d0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "gap");
    test_range();
    test_abort();
    test_len0();
    test_back_to_back();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
